// File: rtl/cpu_types.sv
// Shared pipeline types for the RV32 core: instruction fields, stage status and execute-stage encodings.
// No logic; types, state constants and small op-classification helpers only.
// Consumed by execute, muldiv_unit and the neighbouring pipeline stages.
package cpu_types;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic {
        SRC_REG, SRC_IMM
    } alu_src_t;

    typedef enum logic [3:0] {
        MD_NONE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } muldiv_op_t;

    // Multiply/divide FSM encoding kept as plain constants for legacy tooling.
    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t IDLE = 2'd0;
    localparam muldiv_state_t BUSY = 2'd1;
    localparam muldiv_state_t DONE = 2'd2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] immediate;
        alu_op_t     alu_op;
        alu_src_t    alu_b_src;
        muldiv_op_t  muldiv_op;
    } instruction_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic [31:0] data;
    } stage_data_t;

    typedef struct packed {
        logic         valid;
        logic         ready;
        instruction_t instruction;
        logic [31:0]  pc;
        logic [31:0]  reg_rd1;
        logic [31:0]  reg_rd2;
        stage_data_t  data;
    } stage_status_t;

    function automatic logic md_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic md_is_rem(input muldiv_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic md_signed_a(input muldiv_op_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // MULHSU takes its second operand as unsigned.
    function automatic logic md_signed_b(input muldiv_op_t op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide engine working on operand magnitudes with a final sign fix-up.
// Latency: DIV*/REM* 1+32 cycles then DONE; MUL* 1+1 (FAST_MUL) or 1+32; div-by-0/overflow go straight to DONE.
// No backpressure of its own: the result is shown for exactly one DONE cycle; flush returns to IDLE.
module muldiv_unit
    import cpu_types::*;
#(
    parameter int FAST_MUL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  muldiv_op_t  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    muldiv_state_t state;
    logic [4:0]    count;
    muldiv_op_t    op_lat;
    logic          sign_a;
    logic          sign_b;
    logic [31:0]   acc_hi;      // remainder (div) or product high half (mul)
    logic [31:0]   acc_lo;      // quotient/dividend (div) or multiplier/product low half (mul)
    logic [31:0]   opb_mag;     // |divisor| or |multiplicand|

    logic          sa, sb, special, fin;
    logic [31:0]   mag_a, mag_b, special_res;
    logic [32:0]   rem_sh, diff, mul_sum;
    logic [31:0]   next_hi, next_lo, quo, rem;
    logic [63:0]   fast_prod, prod, prod_fix;
    logic [31:0]   fixed;

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    // Operand capture terms: signs, magnitudes and the cases that need no iteration.
    always_comb begin
        sa          = md_signed_a(op) & a[31];
        sb          = md_signed_b(op) & b[31];
        mag_a       = sa ? (32'd0 - a) : a;
        mag_b       = sb ? (32'd0 - b) : b;
        special     = 1'b0;
        special_res = 32'd0;
        if (md_is_div(op)) begin
            if (b == 32'd0) begin
                special     = 1'b1;
                special_res = md_is_rem(op) ? a : 32'hFFFF_FFFF;
            end else if (md_signed_a(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                special     = 1'b1;
                special_res = md_is_rem(op) ? 32'd0 : 32'h8000_0000;
            end
        end
    end

    // One radix-2 step (restoring divide or shift-add multiply) and the signed result selection.
    always_comb begin
        rem_sh  = {acc_hi, acc_lo[31]};
        diff    = rem_sh - {1'b0, opb_mag};
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_mag} : 33'd0);
        if (md_is_div(op_lat)) begin
            next_hi = diff[32] ? rem_sh[31:0] : diff[31:0];
            next_lo = {acc_lo[30:0], ~diff[32]};
        end else begin
            next_hi = mul_sum[32:1];
            next_lo = {mul_sum[0], acc_lo[31:1]};
        end
        fast_prod = 64'(acc_lo) * 64'(opb_mag);
        fin       = (state == BUSY) &&
                    (((FAST_MUL != 0) && !md_is_div(op_lat)) || (count == 5'd31));
        prod      = ((FAST_MUL != 0) && !md_is_div(op_lat)) ? fast_prod : {next_hi, next_lo};
        prod_fix  = (sign_a ^ sign_b) ? (64'd0 - prod) : prod;
        quo       = (sign_a ^ sign_b) ? (32'd0 - next_lo) : next_lo;
        rem       = sign_a ? (32'd0 - next_hi) : next_hi;
        case (op_lat)
            MUL:                 fixed = prod_fix[31:0];
            MULH, MULHSU, MULHU: fixed = prod_fix[63:32];
            DIV, DIVU:           fixed = quo;
            REM, REMU:           fixed = rem;
            default:             fixed = 32'd0;
        endcase
    end

    // FSM, iteration counter and datapath registers; flush abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 5'd0;
            op_lat  <= MD_NONE;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            opb_mag <= 32'd0;
            result  <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_lat <= op;
                        sign_a <= sa;
                        sign_b <= sb;
                        count  <= 5'd0;
                        if (special) begin
                            result <= special_res;
                            state  <= DONE;
                        end else begin
                            acc_hi  <= 32'd0;
                            acc_lo  <= mag_a;
                            opb_mag <= mag_b;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    count  <= count + 5'd1;
                    if (fin) begin
                        result <= fixed;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus the multi-cycle RV32M unit, feeding memory_access.
// Latency: ALU ops 0 cycles; muldiv ops as muldiv_unit (result in its DONE cycle).
// Backpressure: stage_out.ready low while a muldiv op is pending; flush or rst force ready high.
module execute
    import cpu_types::*;
#(
    parameter int FAST_MUL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  stage_status_t stage_in,
    output stage_status_t stage_out
);

    logic        is_md, md_start, md_busy, md_done;
    logic [31:0] op_a, op_b, alu_res, md_result;

    assign is_md    = (stage_in.instruction.muldiv_op != MD_NONE);
    assign md_start = stage_in.valid & is_md & ~flush;

    // Operand selection and the combinational ALU.
    always_comb begin
        op_a = stage_in.reg_rd1;
        op_b = (stage_in.instruction.alu_b_src == SRC_IMM) ? stage_in.instruction.immediate
                                                            : stage_in.reg_rd2;
        case (stage_in.instruction.alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << op_b[4:0];
            ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'd0, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> op_b[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = 32'd0;
        endcase
    end

    muldiv_unit #(
        .FAST_MUL (FAST_MUL)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (md_start),
        .op     (stage_in.instruction.muldiv_op),
        .a      (op_a),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Output assembly: pass-through fields, then valid/ready and the result word.
    always_comb begin
        stage_out              = stage_in;
        stage_out.valid        = stage_in.valid & ~flush & ~rst & (~is_md | md_done);
        stage_out.ready        = rst | flush | md_done | ~((stage_in.valid & is_md) | md_busy);
        stage_out.data.data    = is_md ? md_result : alu_res;
        stage_out.data.address = stage_in.valid ? {27'd0, stage_in.instruction.rd} : 32'd0;
        stage_out.data.valid   = stage_out.valid;
    end

endmodule
